// File: rtl/vector_main_memory.sv
// vector_main_memory
//   Main vector data memory beside processing_block. DEPTH words of
//   LANES*ELEM_W bits (32 bf16 lanes = 512 bits by default).
//   One read port and one write port per cycle, write-first forwarding.
//
// Ports
//   clock, reset_n            single clock, async active-low reset
//   load_addr/load_ctrl       PB read request; load_data registered (1-cycle latency)
//   write_addr/data/ctrl      PB write, committed on the sampling edge
//   host_req/we/addr/wdata    low-priority host request, held until host_ack
//   host_rdata/host_ack       host read data and one-cycle completion pulse
//   oob_err                   sticky out-of-range flag, cleared only by reset
module vector_main_memory #(
    parameter int LANES  = 32,
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         load_addr,
    input  logic                      load_ctrl,
    output logic [LANES*ELEM_W-1:0]   load_data,
    input  logic [ADDR_W-1:0]         write_addr,
    input  logic [LANES*ELEM_W-1:0]   write_data,
    input  logic                      write_ctrl,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [ADDR_W-1:0]         host_addr,
    input  logic [LANES*ELEM_W-1:0]   host_wdata,
    output logic [LANES*ELEM_W-1:0]   host_rdata,
    output logic                      host_ack,
    output logic                      oob_err
);

    localparam int W     = LANES * ELEM_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } host_state_t;

    logic [W-1:0]      r_mem [DEPTH];
    host_state_t       r_state;
    logic [W-1:0]      r_load_data;
    logic [W-1:0]      r_host_rdata;
    logic              r_host_ack;
    logic              r_oob_err;

    logic              w_ld_ok;
    logic              w_pw_ok;
    logic              w_h_ok;
    logic              w_host_conflict;
    logic              w_host_go;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [W-1:0]      w_wr_data;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_ok;
    logic [W-1:0]      w_rd_data;
    logic              w_oob_hit;

    assign w_ld_ok = {1'b0, load_addr}  < LIMIT;
    assign w_pw_ok = {1'b0, write_addr} < LIMIT;
    assign w_h_ok  = {1'b0, host_addr}  < LIMIT;

    // Host only competes for the port it needs; PB always wins it.
    assign w_host_conflict = host_we ? write_ctrl : load_ctrl;
    assign w_host_go       = (r_state == S_IDLE) && host_req && !w_host_conflict;

    // Shared write port: PB write, or an accepted host write (never both).
    assign w_wr_en   = write_ctrl ? w_pw_ok : (w_host_go && host_we && w_h_ok);
    assign w_wr_addr = write_ctrl ? write_addr : host_addr;
    assign w_wr_data = write_ctrl ? write_data : host_wdata;

    // Shared read port: PB load, or an accepted host read (never both).
    assign w_rd_addr = load_ctrl ? load_addr : host_addr;
    assign w_rd_ok   = load_ctrl ? w_ld_ok : w_h_ok;

    // Write-first: a same-edge write to the read address is forwarded.
    always_comb begin
        w_rd_data = '0;
        if (!w_rd_ok) begin
            w_rd_data = '0;
        end else if (w_wr_en && (w_wr_addr == w_rd_addr)) begin
            w_rd_data = w_wr_data;
        end else begin
            w_rd_data = r_mem[w_rd_addr[IDX_W-1:0]];
        end
    end

    assign w_oob_hit = (load_ctrl  && !w_ld_ok)
                     | (write_ctrl && !w_pw_ok)
                     | (w_host_go  && !w_h_ok);

    // Storage array is intentionally not reset.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr[IDX_W-1:0]] <= w_wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_load_data <= '0;
            r_oob_err   <= 1'b0;
        end else begin
            if (load_ctrl) begin
                r_load_data <= w_rd_data;
            end
            if (w_oob_hit) begin
                r_oob_err <= 1'b1;
            end
        end
    end

    // Host FSM: the access happens on the accepting edge out of IDLE;
    // RESP is the single ack cycle, after which a held request re-arbitrates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_host_ack <= 1'b0;
                    if (w_host_go) begin
                        r_state    <= S_RESP;
                        r_host_ack <= 1'b1;
                        if (!host_we) begin
                            r_host_rdata <= w_rd_data;
                        end
                    end
                end
                S_RESP: begin
                    r_host_ack <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_host_ack <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign load_data  = r_load_data;
    assign host_rdata = r_host_rdata;
    assign host_ack   = r_host_ack;
    assign oob_err    = r_oob_err;

endmodule
